// File: rtl/add_scheduler.sv
// Round-robin burst scheduler that time-shares one accumulator among NREQ requesters.
// Each grant drives add_value for a latched number of cycles; a clear request is slotted between bursts.
module add_scheduler #(
    parameter int NREQ = 4,
    parameter int VW   = 4,
    parameter int LW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*VW-1:0]       req_value,
    input  logic [NREQ*LW-1:0]       req_len,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clr_req,
    output logic                     clr_ack,
    output logic [VW-1:0]            add_value,
    output logic                     counter_clear,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     burst_done
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, BURST, CLEAR} state_t;

    state_t          state;
    logic [LW-1:0]   remain;
    logic [IW-1:0]   last;
    logic [IW-1:0]   sel;
    logic            any_req;
    logic [LW-1:0]   sel_len;
    logic [LW-1:0]   len_eff;

    // Search starts just after the last winner so every requester is served in turn.
    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        idx     = 0;
        cand    = '0;
        sel     = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last) + k) % NREQ;
            cand = IW'(idx);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !clr_req && any_req)
            req_ready[sel] = 1'b1;
    end

    assign sel_len = req_len[int'(sel)*LW +: LW];
    assign len_eff = (sel_len == '0) ? LW'(1) : sel_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            add_value     <= '0;
            counter_clear <= 1'b0;
            clr_ack       <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            grant_id      <= '0;
            last          <= IW'(NREQ - 1);
            remain        <= '0;
        end else begin
            counter_clear <= 1'b0;
            clr_ack       <= 1'b0;
            burst_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state         <= CLEAR;
                        counter_clear <= 1'b1;
                        clr_ack       <= 1'b1;
                        busy          <= 1'b1;
                    end else if (any_req) begin
                        add_value  <= req_value[int'(sel)*VW +: VW];
                        remain     <= len_eff;
                        grant_id   <= sel;
                        last       <= sel;
                        busy       <= 1'b1;
                        burst_done <= (len_eff == LW'(1));
                        state      <= BURST;
                    end
                end
                BURST: begin
                    // remain counts the current cycle, so done is raised one edge ahead.
                    if (remain == LW'(1)) begin
                        add_value <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        remain     <= remain - LW'(1);
                        burst_done <= (remain == LW'(2));
                    end
                end
                CLEAR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_scheduler.sv
// Directed bench for add_scheduler: cycle table plus round-robin, clear-during-burst and reset-abort sequences.
module tb_add_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_value;
    logic [15:0] req_len;
    logic [3:0]  req_ready;
    logic        clr_req;
    logic        clr_ack;
    logic [3:0]  add_value;
    logic        counter_clear;
    logic        busy;
    logic [1:0]  grant_id;
    logic        burst_done;
    logic [7:0]  count;

    int checks = 0;
    int errors = 0;

    add_scheduler #(.NREQ(4), .VW(4), .LW(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_value(req_value),
        .req_len(req_len), .req_ready(req_ready), .clr_req(clr_req), .clr_ack(clr_ack),
        .add_value(add_value), .counter_clear(counter_clear), .busy(busy),
        .grant_id(grant_id), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    // Accumulator the scheduler feeds.
    always @(posedge clk or negedge reset) begin
        if (!reset)             count <= 8'd0;
        else if (counter_clear) count <= 8'd0;
        else                    count <= count + {4'd0, add_value};
    end

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] value;
        logic [15:0] len;
        logic        clr;
        logic [3:0]  ready;
        logic [3:0]  add;
        logic        done;
        logic        bsy;
        logic        clear;
        logic [1:0]  gid;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; req_value = '0; req_len = '0; clr_req = 1'b0;
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        //        valid    value     len       clr   ready    add  done bsy  clr  gid   cnt
        tbl[0]  = '{4'b0001, 16'h0003, 16'h0004, 1'b0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
        tbl[2]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd3};
        tbl[3]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd6};
        tbl[4]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd9};
        tbl[5]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd12};
        tbl[6]  = '{4'b0001, 16'h0007, 16'h0000, 1'b0, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd12};
        tbl[7]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd7, 1'b1, 1'b1, 1'b0, 2'd0, 8'd12};
        tbl[8]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd19};
        tbl[9]  = '{4'b0100, 16'h0200, 16'h0100, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd19};
        tbl[10] = '{4'b0100, 16'h0200, 16'h0100, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b1, 2'd0, 8'd19};
        tbl[11] = '{4'b0100, 16'h0200, 16'h0100, 1'b0, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[12] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd2, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0};
        tbl[13] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2};

        reset = 1'b0; req_valid = '0; req_value = '0; req_len = '0; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_add", add_value, 0);
        chk("rst_clear", counter_clear, 0);
        chk("rst_ack", clr_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_gid", grant_id, 0);
        next_cycle();
        reset = 1'b1;

        // Single burst, zero-length burst, clear racing a request.
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid; req_value = tbl[i].value;
            req_len = tbl[i].len; clr_req = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("t%0d_ready", i), req_ready, tbl[i].ready);
            chk($sformatf("t%0d_add", i), add_value, tbl[i].add);
            chk($sformatf("t%0d_done", i), burst_done, tbl[i].done);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("t%0d_clear", i), counter_clear, tbl[i].clear);
            chk($sformatf("t%0d_ack", i), clr_ack, tbl[i].clear);
            chk($sformatf("t%0d_gid", i), grant_id, tbl[i].gid);
            chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
            next_cycle();
        end

        // Round-robin across four held requests.
        do_reset();
        req_valid = 4'hF; req_value = 16'h4321; req_len = 16'h2222;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready", g), req_ready, 1 << (g % 4));
            if (g == 4) chk("rr_count20", count, 20);
            next_cycle();
            if (g == 4) req_valid = '0;
            @(negedge clk);
            chk($sformatf("rr%0d_gid", g), grant_id, g % 4);
            chk($sformatf("rr%0d_add1", g), add_value, g % 4 + 1);
            chk($sformatf("rr%0d_ready_burst", g), req_ready, 0);
            next_cycle();
            @(negedge clk);
            chk($sformatf("rr%0d_add2", g), add_value, g % 4 + 1);
            chk($sformatf("rr%0d_done", g), burst_done, 1);
            next_cycle();
        end

        // Clear requested mid-burst: burst finishes, clear, then pending request.
        req_valid = 4'b0010; req_value = 16'h0050; req_len = 16'h0030;
        @(negedge clk);
        chk("cb_accept", req_ready, 2);
        chk("cb_count0", count, 22);
        next_cycle();
        req_valid = 4'b1000; req_value = 16'h1050; req_len = 16'h1030;
        @(negedge clk);
        chk("cb_add_b1", add_value, 5);
        chk("cb_ready_b1", req_ready, 0);
        next_cycle();
        clr_req = 1'b1;
        @(negedge clk);
        chk("cb_add_b2", add_value, 5);
        chk("cb_ack_b2", clr_ack, 0);
        next_cycle();
        @(negedge clk);
        chk("cb_add_b3", add_value, 5);
        chk("cb_done_b3", burst_done, 1);
        next_cycle();
        @(negedge clk);
        chk("cb_idle_ready", req_ready, 0);
        chk("cb_idle_add", add_value, 0);
        chk("cb_idle_count", count, 37);
        chk("cb_idle_clear", counter_clear, 0);
        next_cycle();
        @(negedge clk);
        chk("cb_clear", counter_clear, 1);
        chk("cb_ack", clr_ack, 1);
        chk("cb_busy", busy, 1);
        chk("cb_clear_ready", req_ready, 0);
        next_cycle();
        clr_req = 1'b0;
        @(negedge clk);
        chk("cb_count_cleared", count, 0);
        chk("cb_resume_ready", req_ready, 8);
        chk("cb_ack_low", clr_ack, 0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("cb_r3_add", add_value, 1);
        chk("cb_r3_done", burst_done, 1);
        chk("cb_r3_gid", grant_id, 3);
        next_cycle();
        @(negedge clk);
        chk("cb_final_count", count, 1);
        chk("cb_final_busy", busy, 0);

        // Reset during a long burst.
        do_reset();
        req_valid = 4'b0001; req_value = 16'h0002; req_len = 16'h0008;
        @(negedge clk);
        chk("ra_accept", req_ready, 1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("ra_add_b1", add_value, 2);
        next_cycle();
        #2;
        chk("ra_add_pre", add_value, 2);
        reset = 1'b0;
        #1;
        chk("ra_add_async", add_value, 0);
        chk("ra_busy_async", busy, 0);
        chk("ra_done_async", burst_done, 0);
        next_cycle();
        reset = 1'b1;
        req_valid = 4'b1001; req_value = 16'h9002; req_len = 16'h1001;
        @(negedge clk);
        chk("ra_prio0", req_ready, 1);
        next_cycle();
        @(negedge clk);
        chk("ra_gid", grant_id, 0);
        chk("ra_add", add_value, 2);
        chk("ra_done", burst_done, 1);
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("ra_next_ready", req_ready, 8);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("ra_r3_add", add_value, 9);
        chk("ra_r3_gid", grant_id, 3);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_scheduler.md
Name: add_scheduler

Overview:
Round-robin scheduler that shares one counter_with_adder accumulator among NREQ requesters. Each requester asks for a burst: add a 4-bit value for N consecutive cycles. The scheduler grants one burst at a time and drives the accumulator's add_value, which is 0 when idle. It also sequences a synchronous clear of the accumulator on request.

Parameters:
NREQ, 4, number of requesters (2..8)
VW, 4, increment width; matches accumulator add_value
LW, 4, burst-length field width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
req_valid  input  NREQ  per-requester burst request, level
req_value  input  NREQ*VW  increment for requester i at bits [i*VW +: VW]
req_len  input  NREQ*LW  burst length in cycles for requester i at [i*LW +: LW]; 0 is treated as 1
req_ready  output  NREQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i]
clr_req  input  1  accumulator clear request, level, held until clr_ack
clr_ack  output  1  one-cycle pulse, equal to counter_clear
add_value  output  VW  registered increment to accumulator
counter_clear  output  1  registered one-cycle clear to accumulator
busy  output  1  high in BURST or CLEAR
grant_id  output  $clog2(NREQ)  index of the current or last granted requester
burst_done  output  1  one-cycle pulse on the last add cycle of a burst

Behaviour:
- Reset (reset=0, async): state=IDLE; add_value=0; counter_clear=0; clr_ack=0; busy=0; burst_done=0; grant_id=0; rr pointer last=NREQ-1, so requester 0 has top priority first.
- States: IDLE, BURST, CLEAR.
- IDLE:
  - clr_req=1: req_ready=0. Next state is CLEAR; counter_clear and clr_ack are registered 1 for that cycle. clr_req has priority over any req_valid.
  - Else if any req_valid: select the first asserted index searching last+1, last+2, … wrapping modulo NREQ. req_ready[sel]=1 combinationally in that cycle.
  - At that edge: add_value <= req_value[sel]; remain <= max(req_len[sel],1); grant_id <= sel; last <= sel; busy <= 1; state <= BURST.
  - Otherwise add_value stays 0 and req_ready=0.
- BURST:
  - add_value holds the latched value for exactly remain cycles, starting the cycle after acceptance.
  - req_ready=0 throughout.
  - remain decrements each cycle.
  - In the cycle where remain==1: burst_done=1. At the next edge: add_value <= 0, busy <= 0, state <= IDLE.
  - Minimum of one idle cycle between bursts.
- CLEAR: lasts exactly one cycle with counter_clear=1, clr_ack=1, add_value=0, busy=1, then returns to IDLE.
- clr_req asserted during BURST: not aborted. The clear is serviced in the first IDLE cycle after the burst, ahead of pending requests.
- Input changes while in BURST do not affect the latched value or length.
- req_valid dropped before acceptance: the request is withdrawn, with no side effect.
- Sum of increments per burst = value*len. Maximum is 15*15=225. The accumulator handles wrap; the scheduler never saturates.
- Reset mid-burst: add_value returns to 0 immediately (async) and the burst is lost; there is no ready/done pulse.

Test Plan:
1. Reset, then req_valid=0001, value0=3, len0=4 → req_ready[0] pulses for 1 cycle. add_value=3 for 4 cycles, burst_done on the 4th, then 0. Accumulator count=12.
2. All four requesters valid with values 1,2,3,4 and len 2 each, held → grant order 0,1,2,3,0. Each burst is 2 cycles with a 1-cycle gap. After the first four bursts count=20.
3. Burst of value 5, len 3 running; clr_req raised on its 2nd cycle → burst completes (count +15). Next cycle counter_clear=clr_ack=1, count=0. Then pending requests resume.
4. clr_req and req_valid[2] asserted together in IDLE → CLEAR first, with req_ready=0. The next cycle accepts requester 2.
5. req_len=0, value=7 → exactly one add cycle of 7, with burst_done that same cycle.
6. reset driven low on the 2nd cycle of a len-8 burst → add_value=0, busy=0, state IDLE immediately. After release, requester 0 has priority again.
